lcd1602_ctrl: RTL and testbench
===============================

# lcd1602_ctrl

Avalon-MM master that sequences the `lcd1602` character-LCD slave: after reset it waits out the panel power-up time and issues the HD44780 initialisation commands. It then repeatedly refreshes both 16-character lines from an internal 32-byte character buffer that the host fills through a simple write port. It sits between system logic (CPU/debug display writer) and the `lcd1602` slave, owning that slave's bus exclusively.

## Interface
- `PWRUP_CYC`, 750000: cycles waited after reset before the first command (15 ms at 50 MHz).
- `CMD_GAP`, 2000: idle cycles after every accepted command/data write (40 us).
- `CLR_GAP`, 82000: idle cycles after the clear-display command (1.64 ms).
- `clk`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  host buffer write strobe, one cycle per write.
- `wr_addr`  in  5  buffer index: 0-15 line 1, 16-31 line 2.
- `wr_data`  in  8  character code, stored raw.
- `init_done`  out  1  high once all init commands have been accepted.
- `lcd_address`  out  1  0 = instruction, 1 = data; to slave `address`.
- `lcd_chipselect`  out  1  to slave `chipselect`.
- `lcd_write`  out  1  to slave `write`.
- `lcd_writedata`  out  8  to slave `writedata`.
- `lcd_waitrequest`  in  1  from slave `waitrequest`.

## Operation
- States: PWRUP → CMD ↔ GAP → (IDLE) → CMD.
- PWRUP: counts `PWRUP_CYC` cycles, then enters CMD at init step 0.
- Init steps, all with address 0: 0x38 (function set), 0x0C (display on), 0x01 (clear), 0x06 (entry mode).
- After the entry-mode write is accepted, `init_done` rises and stays high until reset.
- A refresh pass has 34 steps: 0x80 (addr 0), chars 0-15 (addr 1), 0xC0 (addr 0), chars 16-31 (addr 1).
- CMD: `lcd_chipselect` = `lcd_write` = 1, with address/data stable, until a cycle with `lcd_waitrequest` = 0. The write is accepted on that edge, then the block enters GAP.
- GAP: counts `CMD_GAP` cycles, or `CLR_GAP` after 0x01. It then advances the step counter and enters CMD, or IDLE at end of pass (see Configuration).
- Char data is a registered read of the buffer, issued in the GAP cycle before CMD.
- Host writes always complete in one cycle; there is no backpressure on the host port.
- Host write to the index being read in the same cycle: the old value is sent, and the new value appears on the next pass.
- Counters are 20 bits wide; all parameters must be < 2^20 and ≥ 1.
- Buffer reset contents: 0x20 (space) in all 32 entries.

## Timing
- All outputs reset to 0: `init_done`, `lcd_address`, `lcd_chipselect`, `lcd_write`, `lcd_writedata`.
- First `lcd_chipselect` is asserted `PWRUP_CYC`+1 cycles after `reset_n` deasserts.
- Each step takes (waitrequest stall cycles + 1) cycles in CMD, plus the gap count in GAP, plus 1 turnaround cycle.
- `lcd_waitrequest` held high indefinitely: the block stays in CMD with outputs unchanged. There is no timeout.
- Reset asserted mid-transaction: outputs drop to 0 immediately. The slave shares this reset, so this is legal.
- A buffer write shows on the panel within at most 2 full passes.

## Configuration
- `LCD1602_DIRTY_EN` defined:
  - A dirty flag is set by any `wr_en` and cleared when a pass starts.
  - At end of pass the block enters IDLE and leaves to start a new pass only when the dirty flag is set.
  - A write during a pass sets the flag, so that pass is followed by another.
  - The flag is set at reset, so the first pass always runs.
- `LCD1602_DIRTY_EN` undefined: no IDLE state; passes repeat back-to-back forever.

## Structure
- Shared package `lcd1602_pkg`:
  - state enum;
  - command constants `LCD_FUNC_SET`, `LCD_DISP_ON`, `LCD_CLEAR`, `LCD_ENTRY`, `LCD_LINE1`, `LCD_LINE2`;
  - `LCD_INIT_STEPS` = 4, `LCD_PASS_STEPS` = 34.
- One sub-module, `lcd1602_charbuf`: 32x8 buffer with one write port and one synchronous read port, reset to 0x20.

## Test plan
- Reset, slave model with `waitrequest` = 0, `PWRUP_CYC`=10, `CMD_GAP`=3, `CLR_GAP`=20 → writes 0x38/0x0C/0x01/0x06 at address 0. `init_done` rises on the 0x06 accept. The gap after 0x01 measures 20 cycles.
- Host writes "HELLO" to 0-4 and "WORLD" to 16-20 → the next pass is 0x80, `H E L L O` plus 11×0x20, then 0xC0, `W O R L D` plus 11×0x20.
- Slave holds `waitrequest` high for 7 cycles on step 0x80 → outputs stable for 8 cycles, exactly one accept, no duplicate write.
- Host write to index 3 on the same cycle the sequencer reads index 3 → old char is sent this pass, new char next pass.
- `reset_n` pulsed low mid-pass during CMD → all outputs 0 that cycle, and the full PWRUP plus init sequence repeats.
- `LCD1602_DIRTY_EN` defined with no host writes after the first pass → the bus stays idle. A single `wr_en` starts exactly one more pass.

Source files
------------

// File: rtl/lcd1602_pkg.sv
// ---------------------------------------------------------------------------
// lcd1602_pkg
//
// Shared definitions for the lcd1602 controller slice.
//
// Contents:
//   lcd_state_e            sequencer state encoding
//   LCD_* command bytes    HD44780 instructions issued by the sequencer
//   LCD_INIT_STEPS         number of power-up initialisation writes
//   LCD_PASS_STEPS         number of writes in one full-screen refresh pass
//   lcd_step_* helpers     decode a unified step index into bus content
//
// Step numbering is unified across init and refresh so one counter drives
// the whole sequence:
//   0..3    init commands (0x38, 0x0C, 0x01, 0x06)
//   4       set DDRAM address line 1 (0x80)
//   5..20   characters 0..15
//   21      set DDRAM address line 2 (0xC0)
//   22..37  characters 16..31
// After step 37 the counter wraps to 4, never back into the init range.
//
// Optional feature macro used by the top level: LCD1602_DIRTY_EN.
// ---------------------------------------------------------------------------
package lcd1602_pkg;

    typedef enum logic [1:0] {
        ST_PWRUP = 2'd0,
        ST_CMD   = 2'd1,
        ST_GAP   = 2'd2,
        ST_IDLE  = 2'd3
    } lcd_state_e;

    localparam logic [7:0] LCD_FUNC_SET = 8'h38;
    localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
    localparam logic [7:0] LCD_CLEAR    = 8'h01;
    localparam logic [7:0] LCD_ENTRY    = 8'h06;
    localparam logic [7:0] LCD_LINE1    = 8'h80;
    localparam logic [7:0] LCD_LINE2    = 8'hC0;

    localparam int LCD_INIT_STEPS = 4;
    localparam int LCD_PASS_STEPS = 34;

    // Landmarks in the unified step index.
    localparam logic [5:0] LCD_STEP_CLEAR    = 6'd2;
    localparam logic [5:0] LCD_STEP_ENTRY    = 6'(LCD_INIT_STEPS - 1);
    localparam logic [5:0] LCD_STEP_PASS0    = 6'(LCD_INIT_STEPS);
    localparam logic [5:0] LCD_STEP_L1_FIRST = 6'(LCD_INIT_STEPS + 1);
    localparam logic [5:0] LCD_STEP_L1_LAST  = 6'(LCD_INIT_STEPS + 16);
    localparam logic [5:0] LCD_STEP_LINE2    = 6'(LCD_INIT_STEPS + 17);
    localparam logic [5:0] LCD_STEP_L2_FIRST = 6'(LCD_INIT_STEPS + 18);
    localparam logic [5:0] LCD_STEP_LAST     = 6'(LCD_INIT_STEPS + LCD_PASS_STEPS - 1);

    // True when the step writes a character (data register, address 1).
    function automatic logic lcd_step_is_char(input logic [5:0] step);
        return ((step >= LCD_STEP_L1_FIRST) && (step <= LCD_STEP_L1_LAST)) ||
               ((step >= LCD_STEP_L2_FIRST) && (step <= LCD_STEP_LAST));
    endfunction

    // Buffer index of a character step. Line 2 skips over the 0xC0 step,
    // hence the extra offset of one.
    function automatic logic [4:0] lcd_step_char_idx(input logic [5:0] step);
        logic [4:0] idx;
        if (step <= LCD_STEP_L1_LAST) begin
            idx = 5'(step - LCD_STEP_L1_FIRST);
        end else begin
            idx = 5'(step - LCD_STEP_L1_FIRST - 6'd1);
        end
        return idx;
    endfunction

    // Instruction byte of a command step; zero for character steps.
    function automatic logic [7:0] lcd_step_cmd(input logic [5:0] step);
        logic [7:0] cmd;
        case (step)
            6'd0:           cmd = LCD_FUNC_SET;
            6'd1:           cmd = LCD_DISP_ON;
            LCD_STEP_CLEAR: cmd = LCD_CLEAR;
            LCD_STEP_ENTRY: cmd = LCD_ENTRY;
            LCD_STEP_PASS0: cmd = LCD_LINE1;
            LCD_STEP_LINE2: cmd = LCD_LINE2;
            default:        cmd = 8'h00;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/lcd1602_charbuf.sv
// ---------------------------------------------------------------------------
// lcd1602_charbuf
//
// 32 x 8 character buffer: one write port for the host, one synchronous
// read port for the sequencer. Every entry resets to 0x20 (space).
//
// Ports:
//   clk_i      system clock
//   rst_ni     asynchronous active-low reset
//   wr_en_i    write strobe, one cycle per write
//   wr_addr_i  write index (0-15 line 1, 16-31 line 2)
//   wr_data_i  character code, stored raw
//   rd_en_i    read strobe; rd_data_o updates on the next edge
//   rd_addr_i  read index
//   rd_data_o  registered read data, held until the next read
//
// A read and a write to the same index on the same edge return the value
// stored before that edge (read-before-write).
// ---------------------------------------------------------------------------
module lcd1602_charbuf (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       wr_en_i,
    input  logic [4:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic       rd_en_i,
    input  logic [4:0] rd_addr_i,
    output logic [7:0] rd_data_o
);

    logic [7:0] mem_q [32];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 8'h20;
            end
        end else if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Separate process sampling mem_q before this edge's write lands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_data_q <= 8'h20;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lcd1602_ctrl.sv
// ---------------------------------------------------------------------------
// lcd1602_ctrl
//
// Avalon-MM master driving an lcd1602 character-LCD slave. After reset it
// waits PWRUP_CYC cycles, issues the four HD44780 init commands, then keeps
// refreshing both 16-character lines from an internal 32-byte buffer that
// the host fills through a one-cycle write port.
//
// Parameters:
//   PWRUP_CYC  cycles waited after reset before the first command
//   CMD_GAP    idle cycles after each accepted write
//   CLR_GAP    idle cycles after the clear-display command
//   All must be >= 1 and < 2^20.
//
// Ports:
//   clk              system clock
//   reset_n          asynchronous active-low reset (shared with the slave)
//   wr_en            host buffer write strobe
//   wr_addr          host buffer index (0-15 line 1, 16-31 line 2)
//   wr_data          host character code
//   init_done        high once the entry-mode command has been accepted
//   lcd_address      0 = instruction, 1 = data
//   lcd_chipselect   slave chipselect
//   lcd_write        slave write
//   lcd_writedata    slave write data
//   lcd_waitrequest  slave waitrequest
//
// Bus handshake: in ST_CMD chipselect and write are high and address/data
// are held constant; the write completes on the first rising edge where
// lcd_waitrequest is low, and the bus is released on that same edge.
//
// Optional feature, macro LCD1602_DIRTY_EN: refresh passes only run while a
// dirty flag is set (set by any host write and at reset, cleared as a pass
// starts); otherwise the sequencer parks in ST_IDLE. Without the macro
// passes repeat back-to-back and ST_IDLE is never entered.
// ---------------------------------------------------------------------------
module lcd1602_ctrl #(
    parameter int PWRUP_CYC = 750000,
    parameter int CMD_GAP   = 2000,
    parameter int CLR_GAP   = 82000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    output logic       init_done,
    output logic       lcd_address,
    output logic       lcd_chipselect,
    output logic       lcd_write,
    output logic [7:0] lcd_writedata,
    input  logic       lcd_waitrequest
);

    import lcd1602_pkg::*;

    localparam logic [19:0] PWRUP_LIM = 20'(PWRUP_CYC);
    localparam logic [19:0] CMD_LIM   = 20'(CMD_GAP);
    localparam logic [19:0] CLR_LIM   = 20'(CLR_GAP);

    lcd_state_e  state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic [5:0]  step_q, step_d;
    logic        init_done_q, init_done_d;

    logic [5:0]  next_step;
    logic [19:0] gap_lim;
    logic        in_cmd;
    logic        step_is_char;

    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_data;

`ifdef LCD1602_DIRTY_EN
    logic        dirty_q, dirty_d;
    logic        pass_start;
`endif

    lcd1602_charbuf u_charbuf (
        .clk_i     (clk),
        .rst_ni    (reset_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_addr),
        .rd_data_o (rd_data)
    );

    // Step that follows the current one; the refresh section loops on itself.
    assign next_step = (step_q == LCD_STEP_LAST) ? LCD_STEP_PASS0 : (step_q + 6'd1);
    assign gap_lim   = (step_q == LCD_STEP_CLEAR) ? CLR_LIM : CMD_LIM;

    // -----------------------------------------------------------------------
    // Sequencer next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        step_d      = step_q;
        init_done_d = init_done_q;
        rd_en       = 1'b0;
        rd_addr     = lcd_step_char_idx(next_step);
`ifdef LCD1602_DIRTY_EN
        pass_start  = 1'b0;
`endif

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == PWRUP_LIM) begin
                    cnt_d   = 20'd0;
                    state_d = ST_CMD;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            ST_CMD: begin
                if (!lcd_waitrequest) begin
                    cnt_d   = 20'd0;
                    state_d = ST_GAP;
                    if (step_q == LCD_STEP_ENTRY) begin
                        init_done_d = 1'b1;
                    end
                end
            end

            ST_GAP: begin
                // The cycle where the count expires is the turnaround cycle:
                // it fetches the next character so rd_data is valid and
                // stable for the whole of the following ST_CMD.
                if (cnt_q == gap_lim) begin
                    cnt_d   = 20'd0;
                    step_d  = next_step;
                    state_d = ST_CMD;
                    rd_en   = lcd_step_is_char(next_step);
`ifdef LCD1602_DIRTY_EN
                    if ((step_q == LCD_STEP_LAST) && !dirty_q) begin
                        state_d = ST_IDLE;
                    end else if (next_step == LCD_STEP_PASS0) begin
                        pass_start = 1'b1;
                    end
`endif
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end

            ST_IDLE: begin
`ifdef LCD1602_DIRTY_EN
                // step_q already points at the 0x80 step of the next pass.
                if (dirty_q) begin
                    state_d    = ST_CMD;
                    pass_start = 1'b1;
                end
`else
                state_d = ST_CMD;
`endif
            end

            default: begin
                state_d = ST_PWRUP;
                cnt_d   = 20'd0;
            end
        endcase
    end

`ifdef LCD1602_DIRTY_EN
    // A write landing on the same edge a pass starts keeps the flag set, so
    // that write is guaranteed another pass.
    assign dirty_d = wr_en | (dirty_q & ~pass_start);
`endif

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= 20'd0;
            step_q      <= 6'd0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            init_done_q <= init_done_d;
        end
    end

`ifdef LCD1602_DIRTY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dirty_q <= 1'b1;
        end else begin
            dirty_q <= dirty_d;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Bus outputs: decoded from registers only, so they drop to zero as soon
    // as reset_n falls and never change mid-command.
    // -----------------------------------------------------------------------
    assign in_cmd       = (state_q == ST_CMD);
    assign step_is_char = lcd_step_is_char(step_q);

    assign lcd_chipselect = in_cmd;
    assign lcd_write      = in_cmd;
    assign lcd_address    = in_cmd & step_is_char;
    assign lcd_writedata  = in_cmd ? (step_is_char ? rd_data : lcd_step_cmd(step_q)) : 8'h00;
    assign init_done      = init_done_q;

endmodule

// File: tb/tb_lcd1602_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd1602_ctrl
//
// Self-checking bench for lcd1602_ctrl with short timing parameters
// (PWRUP_CYC=10, CMD_GAP=3, CLR_GAP=20). A slave model answers the bus,
// optionally stalling with waitrequest; every accepted write is popped from
// an expected queue filled by the stimulus thread from its own buffer model.
// Build with LCD1602_DIRTY_EN defined to exercise the dirty-flag variant.
// ---------------------------------------------------------------------------
module tb_lcd1602_ctrl;

    localparam int PWRUP_CYC = 10;
    localparam int CMD_GAP   = 3;
    localparam int CLR_GAP   = 20;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic       clk = 1'b0;
    logic       reset_n;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       init_done;
    logic       lcd_address;
    logic       lcd_chipselect;
    logic       lcd_write;
    logic [7:0] lcd_writedata;
    logic       lcd_waitrequest;

    always #5 clk = ~clk;

    lcd1602_ctrl #(
        .PWRUP_CYC (PWRUP_CYC),
        .CMD_GAP   (CMD_GAP),
        .CLR_GAP   (CLR_GAP)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .init_done       (init_done),
        .lcd_address     (lcd_address),
        .lcd_chipselect  (lcd_chipselect),
        .lcd_write       (lcd_write),
        .lcd_writedata   (lcd_writedata),
        .lcd_waitrequest (lcd_waitrequest)
    );

    // -----------------------------------------------------------------------
    // Scoreboard state
    // -----------------------------------------------------------------------
    logic [8:0] exp_q[$];    // {address, writedata} of each expected write
    int         stall_q[$];  // waitrequest stall cycles for that write
    logic [7:0] model [32];  // bench copy of the character buffer

    int n_vec = 0;
    int n_err = 0;

    int         acc_cnt = 0;
    int         low_len = 0;
    int         run_len = 0;
    int         stall_left = 0;
    int         pwr_low = 0;
    int         low_after [8];
    logic [8:0] run_val = '0;
    logic       cs_prev = 1'b0;
    bit         mon_en = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic report();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    // -----------------------------------------------------------------------
    // Slave model + monitor, evaluated on the falling edge
    // -----------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset_n || !mon_en) begin
            lcd_waitrequest = 1'b0;
            run_len = 0;
            low_len = 0;
            cs_prev = 1'b0;
        end else if (lcd_chipselect) begin
            if (!cs_prev) begin
                if (acc_cnt == 0) pwr_low = low_len;
                else if (acc_cnt <= 8) low_after[acc_cnt-1] = low_len;
                low_len    = 0;
                run_len    = 0;
                run_val    = {lcd_address, lcd_writedata};
                stall_left = (stall_q.size() != 0) ? stall_q[0] : 0;
            end else begin
                check_eq("cmd_stable", {22'd0, lcd_write, lcd_address, lcd_writedata},
                         {22'd0, 1'b1, run_val});
            end
            run_len++;
            if (stall_left > 0) begin
                lcd_waitrequest = 1'b1;
                stall_left--;
            end else begin
                // Write completes on the coming rising edge.
                lcd_waitrequest = 1'b0;
                if (acc_cnt == 3) check_eq("init_done_pre", init_done, 0);
                check_eq("write_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    check_eq("wr_content", {23'd0, lcd_address, lcd_writedata}, {23'd0, exp_q[0]});
                    check_eq("cs_cycles", run_len, stall_q[0] + 1);
                    void'(exp_q.pop_front());
                    void'(stall_q.pop_front());
                end
                acc_cnt++;
            end
            cs_prev = 1'b1;
        end else begin
            lcd_waitrequest = 1'b0;
            low_len++;
            cs_prev = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Driver tasks
    // -----------------------------------------------------------------------
    task automatic push_init();
        exp_q.push_back({1'b0, 8'h38}); stall_q.push_back(0);
        exp_q.push_back({1'b0, 8'h0C}); stall_q.push_back(0);
        exp_q.push_back({1'b0, 8'h01}); stall_q.push_back(0);
        exp_q.push_back({1'b0, 8'h06}); stall_q.push_back(0);
    endtask

    task automatic push_pass(input int stall0);
        exp_q.push_back({1'b0, 8'h80}); stall_q.push_back(stall0);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back({1'b1, model[i]}); stall_q.push_back(0);
        end
        exp_q.push_back({1'b0, 8'hC0}); stall_q.push_back(0);
        for (int i = 16; i < 32; i++) begin
            exp_q.push_back({1'b1, model[i]}); stall_q.push_back(0);
        end
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        model[a] = d;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
    endtask

    // Returns #1 after the rising edge on which accept number n completes.
    task automatic wait_acc(input int n);
        int guard = 0;
        while (acc_cnt < n && guard < 4000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (acc_cnt < n) begin
            check_eq("accept_timeout", acc_cnt, n);
            report();
            $finish;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq(tag, {27'd0, init_done, lcd_address, lcd_chipselect, lcd_write, 1'b0}, 32'd0);
        check_eq({tag, "_data"}, {24'd0, lcd_writedata}, 32'd0);
    endtask

    task automatic idle_check(input int cycles);
        int seen = 0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            if (lcd_chipselect) seen++;
        end
        check_eq("idle_bus", seen, 0);
    endtask

    // -----------------------------------------------------------------------
    // Stimulus
    // -----------------------------------------------------------------------
    localparam int PASS0_END = 4 + 34;  // accept count after first pass

    initial begin
        logic [7:0] hello [5];
        logic [7:0] world [5];
        hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        world = '{8'h57, 8'h4F, 8'h52, 8'h4C, 8'h44};

        reset_n = 1'b0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset_outputs");

        push_init();
        push_pass(0);
        reset_n = 1'b1;

        // Power-up wait and init sequence.
        wait_acc(1);
        check_eq("pwrup_cycles", pwr_low, PWRUP_CYC + 1);
        wait_acc(4);
        check_eq("init_done_post", init_done, 1);
        check_eq("cmd_gap_low", low_after[0], CMD_GAP + 1);
        check_eq("clr_gap_low", low_after[2], CLR_GAP + 1);

        // Fill buffer behind the pass-0 read pointer: HELLO once chars 0-4
        // have gone out, WORLD once chars 16-20 have gone out.
        wait_acc(4 + 6);
        for (int i = 0; i < 5; i++) host_write(5'(i), hello[i]);
        wait_acc(4 + 23);
        for (int i = 0; i < 5; i++) host_write(5'(16 + i), world[i]);
        push_pass(0);

`ifdef LCD1602_DIRTY_EN
        // Writes during pass 0 caused pass 1; nothing since, so stay idle.
        wait_acc(4 + 68);
        idle_check(300);
        push_pass(0);
        host_write(5'd5, 8'h58);
        exp_q[1 + 5] = {1'b1, 8'h58};
        wait_acc(4 + 102);
        idle_check(300);
`else
        // Pass 2: slave stalls the 0x80 write for 7 cycles.
        push_pass(7);

        // Host write to index 3 on the edge the sequencer reads index 3.
        wait_acc(4 + 68 + 4);
        repeat (CMD_GAP) @(negedge clk);
        host_write(5'd3, 8'h50);
        push_pass(0);

        // Reset mid-pass while a command is on the bus.
        wait_acc(4 + 102);
        push_pass(0);
        wait_acc(4 + 102 + 10);
        for (int i = 0; i < 50 && !lcd_chipselect; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("cmd_before_reset", lcd_chipselect, 1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("midpass_reset");
        exp_q.delete();
        stall_q.delete();
        model_reset();
        acc_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        push_init();
        push_pass(0);
        reset_n = 1'b1;
        wait_acc(1);
        check_eq("pwrup_cycles_2", pwr_low, PWRUP_CYC + 1);
        wait_acc(PASS0_END);
`endif

        mon_en = 1'b0;
        check_eq("sb_drained", exp_q.size(), 0);
        report();
        $finish;
    end

endmodule
